serial_adc_ctrl: RTL and testbench
==================================

SERIAL_ADC_CTRL -- requirements
Module: serial_adc_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the conversion word width in bits; legal range 1..32.
REQ-002 The block SHALL have parameter DIV, default 20, meaning the number of clk cycles per adc_sclk half-period; DIV >= 1.
REQ-003 The block SHALL have parameter CONV_CLKS, default 340, meaning the number of clk cycles adc_cs_n is held high between frames for conversion; CONV_CLKS >= 1.
REQ-004 Port clk: input, width 1, system clock; all logic is rising-edge triggered.
REQ-005 Port rstn: input, width 1, reset; asynchronous, active-low.
REQ-006 Port start: input, width 1, single-shot request, sampled on each clk edge.
REQ-007 Port cont: input, width 1, continuous mode enable; level-sensitive.
REQ-008 Port adc_dout: input, width 1, serial data from the converter, MSB first.
REQ-009 Port adc_cs_n: output, width 1, converter chip select, active-low.
REQ-010 Port adc_sclk: output, width 1, converter serial clock.
REQ-011 Port data: output, width DATA_W, last completed conversion word.
REQ-012 Port data_valid: output, width 1, data holds an unconsumed word.
REQ-013 Port data_ready: input, width 1, consumer accepts the word when data_valid is also 1.
REQ-014 Port busy: output, width 1, high in every state except IDLE.
REQ-015 Port overrun: output, width 1, sticky flag indicating an unconsumed word was overwritten.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, SHIFT and CONVWAIT; all outputs are registered.
REQ-017 In IDLE, adc_cs_n=1 and adc_sclk=0; (start=1 or cont=1) on an edge moves to SETUP, and adc_cs_n=0 is driven from that same edge (edge 0).
REQ-018 SETUP SHALL last DIV clk cycles with adc_sclk=0, then enter SHIFT.
REQ-019 SHIFT SHALL run DATA_W bit periods: adc_sclk low for DIV cycles, then high for DIV cycles.
REQ-020 adc_dout SHALL be sampled on the clk edge that drives adc_sclk 0->1 and shifted into an internal register, MSB first.
REQ-021 On the edge that ends the final high phase, the block SHALL drive adc_sclk=0 and adc_cs_n=1, load data from the shift register, set data_valid=1 and enter CONVWAIT.
REQ-022 The data_valid rising edge SHALL occur at edge DIV + 2*DIV*DATA_W counted from edge 0.
REQ-023 CONVWAIT SHALL hold adc_cs_n=1 for CONV_CLKS cycles; it then goes to SETUP (adc_cs_n=0) if cont=1, else to IDLE.
REQ-024 start SHALL be ignored while busy=1, with no queuing.
REQ-025 Deasserting cont mid-frame SHALL complete the current frame and then return to IDLE.
REQ-026 A handshake (data_valid=1 and data_ready=1 on an edge) SHALL clear data_valid and clear overrun.
REQ-027 A word completing while data_valid=1 with no handshake on that edge SHALL overwrite data, keep data_valid=1 and set overrun=1.
REQ-028 A word completing on the same edge as a handshake SHALL load the new data, keep data_valid=1 and leave overrun=0.
REQ-029 data SHALL remain stable while data_valid=1, except under REQ-027 and REQ-028.
REQ-030 All internal counters (divider, bit count, wait count) SHALL restart from 0 on every state entry, with no wrap carried between frames.

Reset
REQ-031 While rstn=0, the outputs SHALL be: adc_cs_n=1, adc_sclk=0, data=0, data_valid=0, busy=0, overrun=0, with FSM in IDLE and all counters and the shift register at 0.
REQ-032 Reset asserted mid-frame SHALL abort immediately: adc_cs_n goes high without waiting for clk, and the partial word is discarded.
REQ-033 After rstn deasserts, the block SHALL ignore start and cont until the first clk edge following deassertion.

Verification
REQ-034 DIV=2, DATA_W=8, start pulse, adc_dout model driving 0xA5 -> adc_cs_n low at edge 0; 8 sclk pulses of period 4 cycles; data=0xA5 with data_valid=1 at edge 34; busy=1 until CONVWAIT ends.
REQ-035 cont=1, data_ready=1 constantly, model words 0x01 then 0x02 -> two consecutive frames separated by CONV_CLKS cycles of cs_n high; data_valid pulses 1 cycle each; overrun stays 0.
REQ-036 cont=1, data_ready=0, two frames -> data=second word, data_valid=1, overrun=1; one data_ready pulse -> data_valid=0, overrun=0.
REQ-037 Completion edge coincides with a data_ready handshake -> data_valid stays 1 with the new word, overrun=0.
REQ-038 rstn pulsed low during bit 4 of SHIFT -> adc_cs_n=1 and adc_sclk=0 asynchronously; all outputs at reset values; the next start produces a full, correct frame.
REQ-039 start pulsed during SHIFT and during CONVWAIT (cont=0) -> ignored, exactly one frame produced; DATA_W=12, DIV=1 regression gives data_valid at edge 25.

Source files
------------

// File: rtl/serial_adc_ctrl.sv
// Serial ADC front end: frames chip select and serial clock, shifts in an
// MSB-first word and hands it to a valid/ready consumer with overrun tracking.
module serial_adc_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 20,
    parameter int CONV_CLKS = 340
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              cont,
    input  logic              adc_dout,
    input  logic              data_ready,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int CMAX = (DIV > CONV_CLKS) ? DIV : CONV_CLKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] CONV_END = CW'(CONV_CLKS - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        CONVWAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              vld_q, vld_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;
    logic              done;
    logic              hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;
        busy_d  = busy_q;
        done    = 1'b0;
        hs      = vld_q & data_ready;

        unique case (state_q)
            IDLE: begin
                if (start || cont) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = '0;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_END) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_END) begin
                    cnt_d = '0;
                    // Rising sclk edge is where the converter bit is captured.
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sh_d   = (sh_q << 1) | DATA_W'(adc_dout);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_END) begin
                            done    = 1'b1;
                            state_d = CONVWAIT;
                            cs_d    = 1'b1;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CONVWAIT: begin
                if (cnt_q == CONV_END) begin
                    cnt_d = '0;
                    sh_d  = '0;
                    if (cont) begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A completing word always lands; overrun only if the old one was lost.
        if (done) begin
            data_d = sh_q;
            vld_d  = 1'b1;
            if (vld_q && !hs) begin
                ovr_d = 1'b1;
            end else if (hs) begin
                ovr_d = 1'b0;
            end
        end else if (hs) begin
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    assign adc_cs_n   = cs_q;
    assign adc_sclk   = sclk_q;
    assign data       = data_q;
    assign data_valid = vld_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_adc_ctrl.sv
// Directed and randomized checks of serial_adc_ctrl against frame-timing
// arithmetic and a queue-driven converter model.
`timescale 1ns/1ps
module tb_serial_adc_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       start_a = 1'b0, cont_a = 1'b0, rdy_a = 1'b0, dout_a;
    logic       cs_a, sclk_a, vld_a, busy_a, ovr_a;
    logic [7:0] data_a;
    logic        start_b = 1'b0, cont_b = 1'b0, rdy_b = 1'b0, dout_b;
    logic        cs_b, sclk_b, vld_b, busy_b, ovr_b;
    logic [11:0] data_b;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Converter models: a new word is taken on each chip-select fall.
    logic [7:0]  qa[$];
    logic [11:0] qb[$];
    logic [7:0]  wa = '0;
    logic [11:0] wb = '0;
    int ia = 0, ib = 0;
    int sr_a[$];
    int csf_a = 0;

    serial_adc_ctrl #(.DATA_W(8), .DIV(2), .CONV_CLKS(10)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .cont(cont_a),
        .adc_dout(dout_a), .data_ready(rdy_a), .adc_cs_n(cs_a),
        .adc_sclk(sclk_a), .data(data_a), .data_valid(vld_a),
        .busy(busy_a), .overrun(ovr_a)
    );

    serial_adc_ctrl #(.DATA_W(12), .DIV(1), .CONV_CLKS(5)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .cont(cont_b),
        .adc_dout(dout_b), .data_ready(rdy_b), .adc_cs_n(cs_b),
        .adc_sclk(sclk_b), .data(data_b), .data_valid(vld_b),
        .busy(busy_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge cs_a) begin
        wa = (qa.size() > 0) ? qa.pop_front() : 8'($urandom);
        ia = 0;
        csf_a = csf_a + 1;
    end
    always @(posedge sclk_a) begin
        ia = ia + 1;
        sr_a.push_back(cyc);
    end
    assign dout_a = (ia < 8) ? wa[7-ia] : 1'b0;

    always @(negedge cs_b) begin
        wb = (qb.size() > 0) ? qb.pop_front() : 12'($urandom);
        ib = 0;
    end
    always @(posedge sclk_b) ib = ib + 1;
    assign dout_b = (ib < 12) ? wb[11-ib] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic go_a(output int e0);
        start_a = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_rdy_a();
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
    endtask

    initial begin
        int e0, f0, bad;
        logic [7:0]  w1, w2, w3, w4;
        logic [11:0] wbx;

        #1 rstn = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(cs_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_vld", 32'(vld_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        start_a = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_cs", 32'(cs_a), 32'd1);

        // Single frame, 0xA5, stray starts in SHIFT and CONVWAIT.
        qa.push_back(8'hA5);
        sr_a.delete();
        f0 = csf_a;
        go_a(e0);
        chk("f1_cs_edge0", 32'(cs_a), 32'd0);
        chk("f1_busy", 32'(busy_a), 32'd1);
        to_cyc(e0 + 10);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        to_cyc(e0 + 33);
        chk("f1_vld_early", 32'(vld_a), 32'd0);
        to_cyc(e0 + 34);
        chk("f1_vld", 32'(vld_a), 32'd1);
        chk("f1_data", 32'(data_a), 32'hA5);
        chk("f1_cs_end", 32'(cs_a), 32'd1);
        chk("f1_sclk_end", 32'(sclk_a), 32'd0);
        chk("f1_nsclk", 32'(sr_a.size()), 32'd8);
        bad = 0;
        foreach (sr_a[k]) if (sr_a[k] != e0 + 4 + 4 * k) bad++;
        chk("f1_sclk_time", 32'(bad), 32'd0);
        to_cyc(e0 + 38);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        to_cyc(e0 + 43);
        chk("f1_busy_wait", 32'(busy_a), 32'd1);
        to_cyc(e0 + 44);
        chk("f1_busy_off", 32'(busy_a), 32'd0);
        to_cyc(e0 + 100);
        chk("f1_one_frame", 32'(csf_a - f0), 32'd1);
        chk("f1_data_hold", 32'(data_a), 32'hA5);
        pulse_rdy_a();
        chk("f1_vld_clr", 32'(vld_a), 32'd0);

        // Continuous, always ready.
        qa.push_back(8'h01);
        qa.push_back(8'h02);
        rdy_a = 1'b1;
        cont_a = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        to_cyc(e0 + 34);
        chk("c_vld1", 32'(vld_a), 32'd1);
        chk("c_data1", 32'(data_a), 32'h01);
        to_cyc(e0 + 35);
        chk("c_pulse1", 32'(vld_a), 32'd0);
        to_cyc(e0 + 43);
        chk("c_gap_cs", 32'(cs_a), 32'd1);
        to_cyc(e0 + 44);
        chk("c_cs2", 32'(cs_a), 32'd0);
        to_cyc(e0 + 50);
        cont_a = 1'b0;
        to_cyc(e0 + 78);
        chk("c_vld2", 32'(vld_a), 32'd1);
        chk("c_data2", 32'(data_a), 32'h02);
        to_cyc(e0 + 79);
        chk("c_pulse2", 32'(vld_a), 32'd0);
        to_cyc(e0 + 87);
        chk("c_busy_last", 32'(busy_a), 32'd1);
        to_cyc(e0 + 88);
        chk("c_idle", 32'(busy_a), 32'd0);
        chk("c_ovr", 32'(ovr_a), 32'd0);
        rdy_a = 1'b0;

        // Continuous, never ready: second word overruns the first.
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        qa.push_back(w1);
        qa.push_back(w2);
        to_cyc(cyc + 3);
        cont_a = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        to_cyc(e0 + 34);
        chk("o_data1", 32'(data_a), 32'(w1));
        chk("o_ovr1", 32'(ovr_a), 32'd0);
        to_cyc(e0 + 50);
        cont_a = 1'b0;
        to_cyc(e0 + 78);
        chk("o_data2", 32'(data_a), 32'(w2));
        chk("o_vld2", 32'(vld_a), 32'd1);
        chk("o_ovr2", 32'(ovr_a), 32'd1);
        to_cyc(e0 + 90);
        pulse_rdy_a();
        chk("o_vld_clr", 32'(vld_a), 32'd0);
        chk("o_ovr_clr", 32'(ovr_a), 32'd0);

        // Completion coinciding with a handshake.
        w3 = 8'($urandom);
        w4 = 8'($urandom);
        qa.push_back(w3);
        qa.push_back(w4);
        cont_a = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        to_cyc(e0 + 50);
        cont_a = 1'b0;
        to_cyc(e0 + 77);
        chk("h_vld_pre", 32'(vld_a), 32'd1);
        rdy_a = 1'b1;
        to_cyc(e0 + 78);
        rdy_a = 1'b0;
        chk("h_vld", 32'(vld_a), 32'd1);
        chk("h_data", 32'(data_a), 32'(w4));
        chk("h_ovr", 32'(ovr_a), 32'd0);
        to_cyc(e0 + 90);

        // Reset during the high phase of bit 4.
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        qa.push_back(w1);
        qa.push_back(w2);
        go_a(e0);
        to_cyc(e0 + 20);
        chk("r_sclk_hi", 32'(sclk_a), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("r_cs", 32'(cs_a), 32'd1);
        chk("r_sclk", 32'(sclk_a), 32'd0);
        chk("r_data", 32'(data_a), 32'd0);
        chk("r_vld", 32'(vld_a), 32'd0);
        chk("r_busy", 32'(busy_a), 32'd0);
        chk("r_ovr", 32'(ovr_a), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        sr_a.delete();
        go_a(e0);
        to_cyc(e0 + 33);
        chk("r2_vld_early", 32'(vld_a), 32'd0);
        to_cyc(e0 + 34);
        chk("r2_vld", 32'(vld_a), 32'd1);
        chk("r2_data", 32'(data_a), 32'(w2));
        chk("r2_nsclk", 32'(sr_a.size()), 32'd8);
        to_cyc(e0 + 50);

        // 12-bit word, DIV=1 instance.
        wbx = 12'($urandom);
        qb.push_back(wbx);
        start_b = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_cs", 32'(cs_b), 32'd0);
        to_cyc(e0 + 24);
        chk("b_vld_early", 32'(vld_b), 32'd0);
        to_cyc(e0 + 25);
        chk("b_vld", 32'(vld_b), 32'd1);
        chk("b_data", 32'(data_b), 32'(wbx));
        to_cyc(e0 + 29);
        chk("b_busy", 32'(busy_b), 32'd1);
        to_cyc(e0 + 30);
        chk("b_idle", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
